// File: rtl/expr_seq_ctrl_if.sv
// Character-in / result-out bundle for the expression sequencer.
// Pure wiring, no latency of its own.
// in_ready is the only backpressure signal; results are strobed with no stall.
interface expr_seq_ctrl_if #(
   parameter int RES_W = 16
);
   logic [7:0]       in;
   logic             in_valid;
   logic             in_ready;
   logic [RES_W-1:0] res;
   logic             res_valid;
   logic             res_err;
   logic             busy;

   // Character source / result consumer side.
   modport master (
      output in, in_valid,
      input  in_ready, res, res_valid, res_err, busy
   );

   // Evaluator side.
   modport slave (
      input  in, in_valid,
      output in_ready, res, res_valid, res_err, busy
   );
endinterface

// File: rtl/expr_seq_ctrl.sv
// Streaming evaluator for single-digit "+"/"*" expressions closed by "=".
// Result strobes one cycle after "="; each "*" operand costs 4 extra cycles.
// in_ready drops during the 4-cycle shift-add multiply and is high otherwise.
module expr_seq_ctrl #(
   parameter int RES_W = 16
) (
   input  logic           clk,
   input  logic           clr,
   expr_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EXP_OP  = 3'd1,
      EXP_DIG = 3'd2,
      MUL     = 3'd3,
      ERR     = 3'd4
   } state_t;

   state_t           state, state_n;
   logic [RES_W-1:0] sum, sum_n;
   logic [RES_W-1:0] term, term_n;
   logic [RES_W-1:0] mcand, mcand_n;
   logic [3:0]       mplier, mplier_n;
   logic [1:0]       cnt, cnt_n;
   logic             pend_mul, pend_mul_n;
   logic [RES_W-1:0] res_q, res_n;
   logic             err_q, err_n;
   logic             vld_q, vld_n;

   logic             accept;
   logic             is_dig;
   logic             is_eq;
   logic             is_add;
   logic             is_mul;
   logic [RES_W-1:0] dig_val;

   assign bus.in_ready  = (state != MUL);
   assign bus.busy      = (state != IDLE);
   assign bus.res       = res_q;
   assign bus.res_err   = err_q;
   assign bus.res_valid = vld_q;

   assign accept  = bus.in_valid && (state != MUL);
   assign is_dig  = (bus.in >= 8'h30) && (bus.in <= 8'h39);
   assign is_add  = (bus.in == 8'h2B);
   assign is_mul  = (bus.in == 8'h2A);
   assign is_eq   = (bus.in == 8'h3D);
   // ASCII digits 0x30..0x39 carry their value in the low nibble.
   assign dig_val = {{(RES_W-4){1'b0}}, bus.in[3:0]};

   // State and datapath registers; clr wipes any partial expression at once.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= IDLE;
         sum      <= '0;
         term     <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         pend_mul <= 1'b0;
         res_q    <= '0;
         err_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         state    <= state_n;
         sum      <= sum_n;
         term     <= term_n;
         mcand    <= mcand_n;
         mplier   <= mplier_n;
         cnt      <= cnt_n;
         pend_mul <= pend_mul_n;
         res_q    <= res_n;
         err_q    <= err_n;
         vld_q    <= vld_n;
      end
   end

   // Next-state and datapath update; result registers hold unless a strobe is issued.
   always_comb begin
      state_n    = state;
      sum_n      = sum;
      term_n     = term;
      mcand_n    = mcand;
      mplier_n   = mplier;
      cnt_n      = cnt;
      pend_mul_n = pend_mul;
      res_n      = res_q;
      err_n      = err_q;
      vld_n      = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               if (is_dig) begin
                  sum_n   = '0;
                  term_n  = dig_val;
                  state_n = EXP_OP;
               end else if (is_eq) begin
                  res_n   = '0;
                  err_n   = 1'b1;
                  vld_n   = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = ERR;
               end
            end
         end

         EXP_OP: begin
            if (accept) begin
               if (is_add) begin
                  // Fold the finished product chain into the running sum.
                  sum_n      = sum + term;
                  pend_mul_n = 1'b0;
                  state_n    = EXP_DIG;
               end else if (is_mul) begin
                  pend_mul_n = 1'b1;
                  state_n    = EXP_DIG;
               end else if (is_eq) begin
                  res_n   = sum + term;
                  err_n   = 1'b0;
                  vld_n   = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = ERR;
               end
            end
         end

         EXP_DIG: begin
            if (accept) begin
               if (is_dig) begin
                  if (pend_mul) begin
                     // term becomes the product accumulator for the multiply.
                     mcand_n  = term;
                     mplier_n = bus.in[3:0];
                     term_n   = '0;
                     cnt_n    = 2'd0;
                     state_n  = MUL;
                  end else begin
                     term_n  = dig_val;
                     state_n = EXP_OP;
                  end
               end else if (is_eq) begin
                  res_n   = '0;
                  err_n   = 1'b1;
                  vld_n   = 1'b1;
                  state_n = IDLE;
               end else begin
                  state_n = ERR;
               end
            end
         end

         MUL: begin
            // One multiplier bit per cycle, LSB first; input is not sampled here.
            if (mplier[0]) begin
               term_n = term + mcand;
            end
            mcand_n  = mcand << 1;
            mplier_n = mplier >> 1;
            cnt_n    = cnt + 2'd1;
            if (cnt == 2'd3) begin
               state_n = EXP_OP;
            end
         end

         ERR: begin
            if (accept && is_eq) begin
               res_n   = '0;
               err_n   = 1'b1;
               vld_n   = 1'b1;
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_expr_seq_ctrl.sv
// Randomized bench for expr_seq_ctrl against a token-level expression model.
// Outputs compared every cycle #1 after the rising edge; inputs driven on the falling edge.
// Directed streams pin known results; a random phase covers gaps, junk and clr.
module tb_expr_seq_ctrl;

   localparam int RES_W = 16;

   logic clk;
   logic clr;

   expr_seq_ctrl_if #(.RES_W(RES_W)) bus ();

   expr_seq_ctrl #(.RES_W(RES_W)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model: accepted characters of the current expression.
   byte              expr_q[$];
   int               mul_left;
   bit               m_valid;
   bit               m_busy;
   logic [RES_W-1:0] m_res;
   bit               m_err;

   // Observations gathered by the compare process.
   int               strobes;
   int               low_cnt;
   logic [RES_W-1:0] last_res;
   logic             last_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_dig(byte c);
      return (c >= "0") && (c <= "9");
   endfunction

   function automatic bit is_op(byte c);
      return (c == "+") || (c == "*");
   endfunction

   // Digit, op, digit, op ... with nothing else allowed.
   function automatic bit prefix_ok();
      foreach (expr_q[i]) begin
         if ((i % 2) == 0) begin
            if (!is_dig(expr_q[i])) return 1'b0;
         end else begin
            if (!is_op(expr_q[i])) return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   // Sum of products over the buffered tokens; products bind tighter than sums.
   task automatic model_eval();
      logic [31:0] total;
      logic [31:0] prod;
      if (!prefix_ok() || (expr_q.size() % 2) == 0) begin
         m_res = '0;
         m_err = 1'b1;
      end else begin
         total = 0;
         prod  = 32'(expr_q[0] - "0");
         for (int i = 1; i < expr_q.size(); i += 2) begin
            if (expr_q[i] == "*") begin
               prod = prod * 32'(expr_q[i+1] - "0");
            end else begin
               total = total + prod;
               prod  = 32'(expr_q[i+1] - "0");
            end
         end
         total = total + prod;
         m_res = total[RES_W-1:0];
         m_err = 1'b0;
      end
   endtask

   task automatic model_reset();
      expr_q.delete();
      mul_left = 0;
      m_valid  = 1'b0;
      m_busy   = 1'b0;
      m_res    = '0;
      m_err    = 1'b0;
   endtask

   // Advance the model across one rising edge with the given input.
   task automatic model_step(input bit v, input byte ch);
      m_valid = 1'b0;
      if (mul_left > 0) begin
         mul_left--;
      end else if (v) begin
         if (ch == "=") begin
            model_eval();
            m_valid = 1'b1;
            m_busy  = 1'b0;
            expr_q.delete();
         end else begin
            if (is_dig(ch) && expr_q.size() > 0 && expr_q[$] == "*" && prefix_ok())
               mul_left = 4;
            expr_q.push_back(ch);
            m_busy = 1'b1;
         end
      end
   endtask

   // Every cycle: DUT outputs against the model's post-edge prediction.
   always @(posedge clk) begin
      #1;
      chk("in_ready",  32'(bus.in_ready),  32'(mul_left == 0));
      chk("busy",      32'(bus.busy),      32'(m_busy));
      chk("res_valid", 32'(bus.res_valid), 32'(m_valid));
      chk("res",       32'(bus.res),       32'(m_res));
      chk("res_err",   32'(bus.res_err),   32'(m_err));
      if (bus.res_valid === 1'b1) begin
         strobes++;
         last_res = bus.res;
         last_err = bus.res_err;
      end
      if (bus.in_ready === 1'b0) low_cnt++;
   end

   task automatic drive(input bit v, input byte ch);
      @(negedge clk);
      bus.in_valid = v;
      bus.in       = ch;
      model_step(v, ch);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'h00);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr          = 1'b1;
      bus.in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Random idle gap, then hold the character until the model says it is taken.
   task automatic send(input byte c);
      int g;
      g = $urandom_range(0, 2);
      repeat (g) drive(1'b0, byte'($urandom_range(32, 126)));
      while (mul_left != 0) drive(1'($urandom_range(0, 1)), "=");
      drive(1'b1, c);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
      idle(2);
   endtask

   function automatic byte rand_char();
      int r;
      r = $urandom_range(0, 99);
      if (r < 50)      return byte'("0" + $urandom_range(0, 9));
      else if (r < 65) return "+";
      else if (r < 78) return "*";
      else if (r < 92) return "=";
      else             return "a";
   endfunction

   initial begin
      int s0;
      strobes      = 0;
      low_cnt      = 0;
      last_res     = '0;
      last_err     = 1'b0;
      clr          = 1'b1;
      bus.in       = 8'h00;
      bus.in_valid = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      clr = 1'b0;

      s0 = strobes;
      send_str("3+4=");
      chk("p_3p4_strobes", 32'(strobes - s0), 32'd1);
      chk("p_3p4_res", 32'(last_res), 32'd7);
      chk("p_3p4_err", 32'(last_err), 32'd0);

      low_cnt = 0;
      send_str("2+3*4=");
      chk("p_mul_stall", 32'(low_cnt), 32'd4);
      chk("p_2p3m4_res", 32'(last_res), 32'd14);
      chk("p_2p3m4_err", 32'(last_err), 32'd0);

      send_str("9*9*9*9*9*9=");
      chk("p_9pow6_res", 32'(last_res), 32'd7153);
      chk("p_9pow6_err", 32'(last_err), 32'd0);

      send_str("3++4=");
      chk("p_dblop_res", 32'(last_res), 32'd0);
      chk("p_dblop_err", 32'(last_err), 32'd1);
      send_str("5=");
      chk("p_5_res", 32'(last_res), 32'd5);
      chk("p_5_err", 32'(last_err), 32'd0);

      s0 = strobes;
      send_str("=");
      chk("p_eq_err", 32'(last_err), 32'd1);
      send_str("a=");
      chk("p_junk_strobes", 32'(strobes - s0), 32'd2);
      chk("p_junk_res", 32'(last_res), 32'd0);
      chk("p_junk_err", 32'(last_err), 32'd1);

      // clr lands in the second multiply cycle after "8" is taken.
      s0 = strobes;
      for (int i = 0; i < 3; i++) send(i == 0 ? "7" : (i == 1 ? "*" : "8"));
      idle(1);
      pulse_clr();
      chk("p_clr_nostrobe", 32'(strobes - s0), 32'd0);
      chk("p_clr_ready", 32'(bus.in_ready), 32'd1);
      send_str("1=");
      chk("p_clr_strobes", 32'(strobes - s0), 32'd1);
      chk("p_clr_res", 32'(last_res), 32'd1);

      // Random phase: mostly well-formed chains, sprinkled with junk and clr.
      for (int n = 0; n < 150; n++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind < 5) begin
            int terms;
            terms = $urandom_range(1, 5);
            for (int t = 0; t < terms; t++) begin
               if (t > 0) send($urandom_range(0, 1) ? "+" : "*");
               send(byte'("0" + $urandom_range(0, 9)));
            end
            send("=");
         end else if (kind < 9) begin
            int len;
            len = $urandom_range(1, 6);
            for (int t = 0; t < len; t++) send(rand_char());
            send("=");
         end else begin
            send(byte'("0" + $urandom_range(0, 9)));
            send("*");
            send(byte'("0" + $urandom_range(0, 9)));
            idle($urandom_range(0, 3));
            pulse_clr();
         end
      end
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
